// File: rtl/riscv_pkg.sv
// Shared core definitions: DataRAM geometry and the read-return owner encoding.
package riscv_pkg;
   localparam int DMEM_ADDR_WIDTH = 8;
   localparam int XLEN            = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_EXT  = 2'd2
   } owner_e;
endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataRAM between the MEM stage and an external loader/debug port.
// Core has default priority; ext is forced through after STARVE_LIMIT consecutive lost cycles.
module dmem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = XLEN,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  core_rd,
   input  logic                  core_wr,
   input  logic [ADDR_WIDTH-1:0] core_addr,
   input  logic [DATA_WIDTH-1:0] core_wdata,
   output logic                  core_stall,
   output logic [DATA_WIDTH-1:0] core_rdata,
   output logic                  core_rvalid,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   output logic                  ext_gnt,
   output logic [DATA_WIDTH-1:0] ext_rdata,
   output logic                  ext_rvalid,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   owner_e           rd_owner_q, rd_owner_d;

   logic core_act;
   logic force_ext;
   logic ext_win;
   logic core_win;

   always_comb begin
      // A store with core_rd also set is just a store.
      core_act  = core_rd | core_wr;
      force_ext = core_act & ext_req & (wait_cnt_q == LIMIT_C);
      ext_win   = ~clear & ext_req & (~core_act | force_ext);
      core_win  = ~clear & core_act & ~force_ext;

      ext_gnt    = ext_win;
      core_stall = ~clear & force_ext;

      mem_addr = ext_win ? ext_addr  : core_addr;
      mem_din  = ext_win ? ext_wdata : core_wdata;
      mem_wren = ext_win ? ext_we    : (core_win & core_wr);

      wait_cnt_d = wait_cnt_q;
      if (clear || !ext_req || ext_win) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q < LIMIT_C) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end

      rd_owner_d = OWN_NONE;
      if (ext_win && !ext_we) begin
         rd_owner_d = OWN_EXT;
      end else if (core_win && !core_wr) begin
         rd_owner_d = OWN_CORE;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         wait_cnt_q <= '0;
         rd_owner_q <= OWN_NONE;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Read data is shared; only the owner's rvalid qualifies it. A clear drops the in-flight read.
   assign core_rvalid = ~clear & (rd_owner_q == OWN_CORE);
   assign ext_rvalid  = ~clear & (rd_owner_q == OWN_EXT);
   assign core_rdata  = mem_dout;
   assign ext_rdata   = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a shadow-memory model.
module tb_dmem_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int LIMIT = 4;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic          core_rd = 1'b0, core_wr = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic          core_stall, core_rvalid;
   logic [DW-1:0] core_rdata;
   logic          ext_req = 1'b0, ext_we = 1'b0;
   logic [AW-1:0] ext_addr = '0;
   logic [DW-1:0] ext_wdata = '0;
   logic          ext_gnt, ext_rvalid;
   logic [DW-1:0] ext_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_wren;
   logic [DW-1:0] mem_dout = '0;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .clear(clear),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout)
   );

   // DataRAM stand-in: registered read, written only by what the DUT drives.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
   always @(posedge clock) begin
      if (mem_wren) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: shadow memory, count of consecutive ext losses, expected pending read.
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   initial for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
   int            losses = 0;
   int            owner = 0;          // 0 none, 1 core, 2 ext
   logic [DW-1:0] exp_data = '0;
   bit            started = 1'b0;
   bit            last_egnt = 1'b0;
   bit            last_stall = 1'b0;

   always @(negedge clock) begin
      bit act, forced, egnt, cgnt, ewren;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] edin;
      if (clear) started = 1'b1;
      if (started) begin
         act    = core_rd | core_wr;
         forced = !clear && act && ext_req && (losses == LIMIT);
         egnt   = !clear && ext_req && (!act || forced);
         cgnt   = !clear && act && !forced;
         ewren  = egnt ? ext_we : (cgnt && core_wr);
         eaddr  = egnt ? ext_addr : core_addr;
         edin   = egnt ? ext_wdata : core_wdata;

         chk("ext_gnt", DW'(ext_gnt), DW'(egnt));
         chk("core_stall", DW'(core_stall), DW'(forced));
         chk("mem_wren", DW'(mem_wren), DW'(ewren));
         if (!clear) chk("mem_addr", DW'(mem_addr), DW'(eaddr));
         if (ewren) chk("mem_din", mem_din, edin);
         chk("core_rvalid", DW'(core_rvalid), DW'(!clear && owner == 1));
         chk("ext_rvalid", DW'(ext_rvalid), DW'(!clear && owner == 2));
         if (!clear && owner == 1) chk("core_rdata", core_rdata, exp_data);
         if (!clear && owner == 2) chk("ext_rdata", ext_rdata, exp_data);

         if (clear) begin
            losses = 0;
            owner  = 0;
         end else begin
            if (egnt || !ext_req) losses = 0;
            else if (losses < LIMIT) losses++;
            if (egnt && !ext_we) begin
               owner = 2; exp_data = shadow[ext_addr];
            end else if (cgnt && !core_wr) begin
               owner = 1; exp_data = shadow[core_addr];
            end else begin
               owner = 0;
            end
            if (ewren) shadow[eaddr] = edin;
         end
         last_egnt  = egnt;
         last_stall = forced;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      core_rd = 0; core_wr = 0; ext_req = 0; ext_we = 0;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      // Reset with a core read presented.
      clear = 1; core_rd = 1; core_addr = 8'd3; ext_req = 1; ext_addr = 8'd4;
      #1; settle();
      chk("rst_wren", DW'(mem_wren), 0);
      chk("rst_gnt", DW'(ext_gnt), 0);
      chk("rst_stall", DW'(core_stall), 0);
      step(); settle();
      chk("rst_rvalid", DW'(core_rvalid | ext_rvalid), 0);
      step();
      clear = 0; idle(); settle();
      chk("post_rst_core_rvalid", DW'(core_rvalid), 0);

      // Core store then load.
      step(); core_wr = 1; core_addr = 8'd5; core_wdata = 32'hDEADBEEF; settle();
      chk("core_wr_wren", DW'(mem_wren), 1);
      step(); core_wr = 0; core_rd = 1; core_addr = 8'd5;
      step(); idle(); settle();
      chk("core_rd_rvalid", DW'(core_rvalid), 1);
      chk("core_rd_data", core_rdata, 32'hDEADBEEF);

      // Ext read alone.
      step(); ext_req = 1; ext_we = 0; ext_addr = 8'd5; settle();
      chk("ext_rd_gnt", DW'(ext_gnt), 1);
      step(); idle(); settle();
      chk("ext_rd_rvalid", DW'(ext_rvalid), 1);
      chk("ext_rd_data", ext_rdata, 32'hDEADBEEF);
      chk("ext_rd_core_rvalid", DW'(core_rvalid), 0);

      // Starvation: forced ext write on cycle 5 only.
      step(); core_rd = 1; core_addr = 8'd0;
      ext_req = 1; ext_we = 1; ext_addr = 8'd9; ext_wdata = 32'h12345678;
      for (int c = 1; c <= 5; c++) begin
         settle();
         chk($sformatf("starve_gnt_c%0d", c), DW'(ext_gnt), DW'(c == 5));
         chk($sformatf("starve_stall_c%0d", c), DW'(core_stall), DW'(c == 5));
         step();
      end
      ext_req = 0; settle();
      chk("starve_c6_stall", DW'(core_stall), 0);
      core_addr = 8'd9;
      step(); settle();
      chk("starve_mem9", core_rdata, 32'h12345678);

      // Interleaved: core read cycle 4, forced ext read cycle 5.
      step(); idle(); step();
      core_rd = 1; core_addr = 8'd9; ext_req = 1; ext_we = 0; ext_addr = 8'd5;
      for (int c = 1; c <= 4; c++) step();
      settle();
      chk("inter_c5_gnt", DW'(ext_gnt), 1);
      chk("inter_c5_core_rvalid", DW'(core_rvalid), 1);
      chk("inter_c5_core_rdata", core_rdata, 32'h12345678);
      chk("inter_c5_ext_rvalid", DW'(ext_rvalid), 0);
      step(); ext_req = 0; core_rd = 0; settle();
      chk("inter_c6_ext_rvalid", DW'(ext_rvalid), 1);
      chk("inter_c6_ext_rdata", ext_rdata, 32'hDEADBEEF);
      chk("inter_c6_core_rvalid", DW'(core_rvalid), 0);

      // Clear while an ext read is in flight.
      step(); ext_req = 1; ext_we = 0; ext_addr = 8'd5; settle();
      chk("rstrd_gnt", DW'(ext_gnt), 1);
      step(); idle(); clear = 1; settle();
      chk("rstrd_rvalid_clear", DW'(ext_rvalid), 0);
      step(); clear = 0; settle();
      chk("rstrd_rvalid_after", DW'(ext_rvalid), 0);
      // Counter restarted at zero: first contended cycle goes to the core.
      core_rd = 1; ext_req = 1; settle();
      chk("rstrd_wait_zero", DW'(ext_gnt), 0);
      step(); idle();

      // Randomized traffic; held requests respect the handshake.
      for (int n = 0; n < 3000; n++) begin
         step();
         clear = ($urandom_range(0, 99) == 0);
         if (!(ext_req && !last_egnt)) begin
            ext_req   = ($urandom_range(0, 2) != 0);
            ext_we    = $urandom_range(0, 1);
            ext_addr  = AW'($urandom_range(0, 15));
            ext_wdata = $urandom;
         end
         if (!last_stall) begin
            core_rd    = ($urandom_range(0, 2) != 0);
            core_wr    = ($urandom_range(0, 3) == 0);
            core_addr  = AW'($urandom_range(0, 15));
            core_wdata = $urandom;
         end
      end
      step(); idle(); step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
